seg7_mmio_display: RTL and testbench
====================================

Name: seg7_mmio_display

Overview:
Memory-mapped 4-digit seven-segment display peripheral on the SoC data-memory store path, downstream of skylark_core.
- Snoops core store traffic (write enable, address, data) and latches digit values into its own registers.
- Time-multiplexes the four digits onto the board anode/cathode pins, replacing the ad-hoc scan logic in the SoC top.
- Provides combinational readback so loads from its window return the register contents.

Parameters:
- BASE_ADDR, 0: word index of digit register 0; window is BASE_ADDR..BASE_ADDR+4.
- REFRESH_BITS, 18: each digit is driven for 2^REFRESH_BITS clk cycles; a bench uses 2.
- ADDR_W, 32: width of addr.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- we  in  1  store strobe from core (MemWriteW).
- addr  in  ADDR_W  word index from core (ALUResultW), unsigned compare.
- wdata  in  32  store data.
- hit  out  1  addr lies inside window (combinational).
- rdata  out  32  readback data (combinational).
- an  out  4  anodes, active-low; an[3] is leftmost digit.
- seg  out  7  cathodes GFEDCBA, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
Interface: reset is asynchronous and active-high; the clock is clk.

Registers:
- DIG0..DIG3 at BASE_ADDR+0..+3, 4 bits each, taken from wdata[3:0].
- CTRL at BASE_ADDR+4: bit0 EN, bits[7:4] DPMASK (bit 4+k lights dp on digit k).
- Write occurs at the clk edge where we=1 and addr hits. Misses are ignored.
- Only the low bits are stored; upper wdata bits are dropped.

Readback:
- rdata = zero-extended register when hit=1, else 0.
- Not affected by EN.

Reset values:
- DIG0..3 = 0, CTRL = 0x01.
- refresh counter = 0, digit pointer = 0.
- an = 4'b1111, seg = 7'b1111111, dp = 1.

Scan:
- REFRESH_BITS-wide counter increments every clk.
- On the wrap from all-ones to 0, the 2-bit pointer advances 0→1→2→3→0.
- Pointer k selects DIGk and drives anode pattern: k=0→0111, 1→1011, 2→1101, 3→1110.
- With REFRESH_BITS=R, each digit holds for exactly 2^R cycles; a full frame is 4·2^R cycles.

Output timing:
- an, seg and dp are registered, one cycle behind pointer and register state.
- A write at edge N appears on seg after edge N+1, provided that digit is being scanned.
- A write and a pointer advance at the same edge are both applied. The output register at N+1 uses the new pointer and the new value.

Enable and decode:
- EN=0: an=1111, seg=1111111, dp=1. Counter and pointer keep running.
- EN 0→1 resumes at the current pointer; there is no frame restart.
- Hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=0100111, D=0100001, E=0000110, F=0001110.
- dp = ~DPMASK[pointer].

Reset mid-operation:
- Immediately forces the reset values, including blanked outputs.
- First lit digit after release is digit 0, one cycle after the first clk edge.

Optional Feature:
SEG7_LZB_EN: leading-zero blanking.
- Defined: digit k (k=0..2) is blanked when it and all digits to its left are 0. Blanked means seg=1111111 while its anode is still driven.
- DIG3 is never blanked, so value 0000 shows "0"; dp is still driven per DPMASK.
- Undefined: all four digits always display.

Test Plan:
- Reset, REFRESH_BITS=2: an=1111, seg=1111111, dp=1 during reset. After release, an=0111 and seg=1000000 for 4 cycles, then an=1011.
- Write addr=BASE+0..3 with data 1,2,3,4 → over a 16-cycle frame seg shows 1111001, 0100100, 0110000, 0011001 in that order. A load from BASE+2 returns rdata=3, hit=1.
- Write addr=BASE+5 or BASE+0 with we=0 → no register change, hit=0 for BASE+5, rdata=0.
- Write CTRL=0x20 → an=1111 for a full frame (EN=0). Then write CTRL=0x21 → dp=0 only while an=1011.
- Write DIG0 on the same edge as the pointer enters digit 0 → seg shows the new value one cycle later, not the old value.
- SEG7_LZB_EN, digits 0,0,5,0 → digits 0 and 1 blank, digit 2 shows 0010010, digit 3 shows 1000000. Assert reset mid-frame → outputs blank immediately, pointer back to 0.

Source files
------------

// File: rtl/seg7_mmio_display.sv
// Memory-mapped 4-digit seven-segment display: snoops core stores into DIG0..3/CTRL and scans the digits.
// Optional leading-zero blanking is compiled in with `define SEG7_LZB_EN.
module seg7_mmio_display #(
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned REFRESH_BITS = 18,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              hit,
   output logic [31:0]       rdata,
   output logic [3:0]        an,
   output logic [6:0]        seg,
   output logic              dp
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(4);

   logic [ADDR_W-1:0]       off;
   logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
   logic [1:0]              ptr_q, ptr_d;
   logic [3:0][3:0]         dig_q, dig_d;
   logic [7:0]              ctrl_q, ctrl_d;
   logic [3:0]              an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    blank;
   logic                    wdata_unused;

   // Cathode pattern GFEDCBA, active-low.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b0100111;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   assign wdata_unused = &{1'b0, wdata[31:8]};

   // Window decode and readback; off is only meaningful when hit=1.
   always_comb begin
      off   = addr - BASE;
      hit   = (addr >= BASE) && (off <= LAST_OFF);
      rdata = '0;
      if (hit) begin
         if (off[2]) rdata = {24'b0, ctrl_q};
         else        rdata = {28'b0, dig_q[off[1:0]]};
      end
   end

   always_comb begin
      dig_d  = dig_q;
      ctrl_d = ctrl_q;
      if (we && hit) begin
         if (off[2]) ctrl_d = wdata[7:0] & 8'hF1;
         else        dig_d[off[1:0]] = wdata[3:0];
      end
   end

   always_comb begin
      cnt_d = cnt_q + REFRESH_BITS'(1);
      ptr_d = (&cnt_q) ? ptr_q + 2'd1 : ptr_q;
   end

   // Digit 0 is leftmost, so "digits to the left" of digit k are 0..k-1.
   always_comb begin
      blank = 1'b0;
`ifdef SEG7_LZB_EN
      case (ptr_q)
         2'd0:    blank = (dig_q[0] == 4'h0);
         2'd1:    blank = (dig_q[0] == 4'h0) && (dig_q[1] == 4'h0);
         2'd2:    blank = (dig_q[0] == 4'h0) && (dig_q[1] == 4'h0) && (dig_q[2] == 4'h0);
         default: blank = 1'b0;
      endcase
`endif
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (ctrl_q[0]) begin
         an_d  = ~(4'b1000 >> ptr_q);
         seg_d = blank ? 7'b1111111 : hex7(dig_q[ptr_q]);
         dp_d  = ~ctrl_q[{1'b1, ptr_q}];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         ptr_q  <= 2'd0;
         dig_q  <= '0;
         ctrl_q <= 8'h01;
         an_q   <= 4'b1111;
         seg_q  <= 7'b1111111;
         dp_q   <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         dig_q  <= dig_d;
         ctrl_q <= ctrl_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_mmio_display.sv
// Directed bench for seg7_mmio_display with REFRESH_BITS=2 (4 cycles per digit, 16-cycle frame).
module tb_seg7_mmio_display;

   localparam int unsigned B = 8;
`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk, reset, we;
   logic [31:0] addr, wdata;
   logic        hit, dp;
   logic [31:0] rdata;
   logic [3:0]  an;
   logic [6:0]  seg;

   int n_cmp = 0;
   int n_fail = 0;
   int ncyc;
   logic [3:0] exp_an [4];

   seg7_mmio_display #(.BASE_ADDR(B), .REFRESH_BITS(2), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
      .hit(hit), .rdata(rdata), .an(an), .seg(seg), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; output after edge n shows digit ((n-1)/4)%4.
   always @(posedge clk or posedge reset) begin
      if (reset) ncyc <= 0;
      else       ncyc <= ncyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic wait_digit(input int k);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (((((ncyc - 1) >> 2) & 3) == k) && (((ncyc - 1) & 3) == 0)) return;
      end
      n_cmp++; n_fail++;
      $display("FAIL wait_digit%0d: timeout, ncyc=%0d", k, ncyc);
   endtask

   task automatic test_reset;
      reset = 1'b1; we = 1'b0; addr = 32'(B); wdata = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
      n_cmp++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      n_cmp++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
      addr = 32'(B + 4); #1;
      n_cmp++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000001", rdata); end
      addr = 32'(B); #1;
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dig0: got %h want 00000000", rdata); end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (an !== 4'b0111) begin n_fail++; $display("FAIL post_reset_an c%0d: got %b want 0111", c, an); end
         n_cmp++; if (seg !== (LZB ? 7'b1111111 : 7'b1000000)) begin n_fail++; $display("FAIL post_reset_seg c%0d: got %b", c, seg); end
         n_cmp++; if (dp !== 1'b1) begin n_fail++; $display("FAIL post_reset_dp c%0d: got %b want 1", c, dp); end
      end
      @(negedge clk);
      n_cmp++; if (an !== 4'b1011) begin n_fail++; $display("FAIL post_reset_next_an: got %b want 1011", an); end
   endtask

   task automatic test_digits;
      logic [6:0] es [4];
      es[0] = 7'b1111001; es[1] = 7'b0100100; es[2] = 7'b0110000; es[3] = 7'b0011001;
      wr(32'(B + 0), 32'hFFFF_FFF1);
      wr(32'(B + 1), 32'h2);
      wr(32'(B + 2), 32'h3);
      wr(32'(B + 3), 32'h4);
      wait_digit(0);
      for (int c = 0; c < 16; c++) begin
         if (c != 0) @(negedge clk);
         n_cmp++; if (an !== exp_an[c / 4]) begin n_fail++; $display("FAIL digits_an c%0d: got %b want %b", c, an, exp_an[c / 4]); end
         n_cmp++; if (seg !== es[c / 4]) begin n_fail++; $display("FAIL digits_seg c%0d: got %b want %b", c, seg, es[c / 4]); end
      end
      addr = 32'(B + 2); #1;
      n_cmp++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL read_dig2: got %h want 00000003", rdata); end
      n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL read_dig2_hit: got %b want 1", hit); end
      addr = 32'(B); #1;
      n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL read_dig0_trunc: got %h want 00000001", rdata); end
   endtask

   task automatic test_miss;
      logic [31:0] ev [5];
      ev[0] = 32'h1; ev[1] = 32'h2; ev[2] = 32'h3; ev[3] = 32'h4; ev[4] = 32'h1;
      @(negedge clk);
      we = 1'b1; addr = 32'(B + 5); wdata = 32'h7; #1;
      n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit_above: got %b want 0", hit); end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL miss_rdata: got %h want 00000000", rdata); end
      addr = 32'(B - 1); #1;
      n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit_below: got %b want 0", hit); end
      @(negedge clk);
      we = 1'b0; addr = 32'(B); wdata = 32'h9;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         addr = 32'(B + i); #1;
         n_cmp++; if (rdata !== ev[i]) begin n_fail++; $display("FAIL miss_keep reg%0d: got %h want %h", i, rdata, ev[i]); end
      end
   endtask

   task automatic test_enable;
      logic [6:0] es [4];
      es[0] = 7'b1111001; es[1] = 7'b0100100; es[2] = 7'b0110000; es[3] = 7'b0011001;
      wr(32'(B + 4), 32'h20);
      addr = 32'(B + 4); #1;
      n_cmp++; if (rdata !== 32'h20) begin n_fail++; $display("FAIL ctrl_read: got %h want 00000020", rdata); end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL disabled_an c%0d: got %b want 1111", c, an); end
         n_cmp++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL disabled_seg c%0d: got %b", c, seg); end
         n_cmp++; if (dp !== 1'b1) begin n_fail++; $display("FAIL disabled_dp c%0d: got %b want 1", c, dp); end
      end
      wr(32'(B + 4), 32'h21);
      wait_digit(0);
      for (int c = 0; c < 16; c++) begin
         if (c != 0) @(negedge clk);
         n_cmp++; if (an !== exp_an[c / 4]) begin n_fail++; $display("FAIL enable_an c%0d: got %b want %b", c, an, exp_an[c / 4]); end
         n_cmp++; if (seg !== es[c / 4]) begin n_fail++; $display("FAIL enable_seg c%0d: got %b want %b", c, seg, es[c / 4]); end
         n_cmp++; if (dp !== ((c / 4) != 1)) begin n_fail++; $display("FAIL enable_dp c%0d: got %b want %b", c, dp, ((c / 4) != 1)); end
      end
   endtask

   task automatic test_same_edge;
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((ncyc % 16) == 15) begin found = 1'b1; break; end
      end
      if (!found) begin n_cmp++; n_fail++; $display("FAIL same_edge_sync: timeout, ncyc=%0d", ncyc); end
      we = 1'b1; addr = 32'(B); wdata = 32'h8;
      @(negedge clk);
      we = 1'b0;
      n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL same_edge_prev_an: got %b want 1110", an); end
      n_cmp++; if (seg !== 7'b0011001) begin n_fail++; $display("FAIL same_edge_prev_seg: got %b want 0011001", seg); end
      @(negedge clk);
      n_cmp++; if (an !== 4'b0111) begin n_fail++; $display("FAIL same_edge_an: got %b want 0111", an); end
      n_cmp++; if (seg !== 7'b0000000) begin n_fail++; $display("FAIL same_edge_seg: got %b want 0000000", seg); end
   endtask

   task automatic test_lzb;
      logic [6:0] es [4];
      es[0] = LZB ? 7'b1111111 : 7'b1000000;
      es[1] = LZB ? 7'b1111111 : 7'b1000000;
      es[2] = 7'b0010010;
      es[3] = 7'b1000000;
      wr(32'(B + 0), 32'h0);
      wr(32'(B + 1), 32'h0);
      wr(32'(B + 2), 32'h5);
      wr(32'(B + 3), 32'h0);
      wait_digit(0);
      for (int c = 0; c < 16; c++) begin
         if (c != 0) @(negedge clk);
         n_cmp++; if (an !== exp_an[c / 4]) begin n_fail++; $display("FAIL lzb_an c%0d: got %b want %b", c, an, exp_an[c / 4]); end
         n_cmp++; if (seg !== es[c / 4]) begin n_fail++; $display("FAIL lzb_seg c%0d: got %b want %b", c, seg, es[c / 4]); end
         n_cmp++; if (dp !== ((c / 4) != 1)) begin n_fail++; $display("FAIL lzb_dp c%0d: got %b want %b", c, dp, ((c / 4) != 1)); end
      end
   endtask

   task automatic test_reset_mid;
      wait_digit(2);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_an: got %b want 1111", an); end
      n_cmp++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL mid_reset_seg: got %b want 1111111", seg); end
      n_cmp++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_reset_dp: got %b want 1", dp); end
      addr = 32'(B + 2); #1;
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_dig2: got %h want 00000000", rdata); end
      addr = 32'(B + 4); #1;
      n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL mid_reset_ctrl: got %h want 00000001", rdata); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (an !== 4'b0111) begin n_fail++; $display("FAIL mid_release_an: got %b want 0111", an); end
      n_cmp++; if (seg !== (LZB ? 7'b1111111 : 7'b1000000)) begin n_fail++; $display("FAIL mid_release_seg: got %b", seg); end
      repeat (4) @(negedge clk);
      n_cmp++; if (an !== 4'b1011) begin n_fail++; $display("FAIL mid_release_next_an: got %b want 1011", an); end
   endtask

   initial begin
      exp_an[0] = 4'b0111; exp_an[1] = 4'b1011; exp_an[2] = 4'b1101; exp_an[3] = 4'b1110;
      test_reset;
      test_digits;
      test_miss;
      test_enable;
      test_same_edge;
      test_lzb;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
